// File: rtl/vend_pkg.sv
// Shared encodings for the vending controller: coin, select and item codes,
// controller states and item prices (all amounts in 10-dollar units).
package vend_pkg;

    localparam logic [1:0] MONEY_10 = 2'b01;
    localparam logic [1:0] MONEY_50 = 2'b10;

    localparam logic [1:0] SEL_20 = 2'b01;
    localparam logic [1:0] SEL_50 = 2'b10;

    localparam logic [1:0] ITEM_NONE = 2'b00;
    localparam logic [1:0] ITEM_20   = 2'b01;
    localparam logic [1:0] ITEM_50   = 2'b10;

    localparam int COIN_10  = 1;
    localparam int COIN_50  = 5;
    localparam int PRICE_20 = 2;
    localparam int PRICE_50 = 5;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CREDIT   = 2'd1,
        ST_DISPENSE = 2'd2,
        ST_CHANGE   = 2'd3
    } state_t;

endpackage

// File: rtl/vend_timer.sv
// Idle-credit timer: counts cycles while run is high, restarts on clear or
// when run drops, and saturates at TIMEOUT_CYCLES with expired held high.
// Only instantiated when VEND_TIMEOUT_EN is defined.
module vend_timer #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] count;

    // Count idle cycles, restarting on any coin or when credit is left.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (!run || clear) begin
            count <= '0;
        end else if (count != CNT_W'(TIMEOUT_CYCLES)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = run && (count == CNT_W'(TIMEOUT_CYCLES));

endmodule

// File: rtl/vend_controller.sv
// Vending machine controller: accepts 10/50-dollar coins, sells 20/50-dollar
// items through a req/ack dispenser, returns change/refunds through a req/ack
// coin return. Optional idle-credit refund timeout under VEND_TIMEOUT_EN.
//
// Handshakes: disp_req / chg_req rise on entering DISPENSE / CHANGE and stay
// high with disp_item / chg_amount stable until the matching ack is sampled
// on a rising edge; the request drops on that same edge.
module vend_controller
    import vend_pkg::*;
#(
    parameter int CREDIT_W       = 4,
    parameter int MAX_CREDIT     = 10,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          money,
    input  logic [1:0]          select,
    input  logic                cancel,
    output logic                disp_req,
    output logic [1:0]          disp_item,
    input  logic                disp_ack,
    output logic                chg_req,
    output logic [CREDIT_W-1:0] chg_amount,
    input  logic                chg_ack,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy,
    output logic                coin_reject
);

    // Extra headroom so credit + 50-dollar coin never wraps before the check.
    localparam int SUM_W = CREDIT_W + 3;

    state_t           state;
    logic             timeout;
    logic             coin_valid;
    logic [SUM_W-1:0] coin_units;
    logic [SUM_W-1:0] price_units;
    logic [SUM_W-1:0] credit_sum;
    logic             overflow;
    logic             can_buy;
    logic             in_take;
    logic             do_cancel;
    logic             do_buy;
    logic             coin_accept;

    // Decode coin/select and resolve cancel > select > money priority.
    always_comb begin
        coin_units  = '0;
        price_units = '0;
        case (money)
            MONEY_10: coin_units = SUM_W'(COIN_10);
            MONEY_50: coin_units = SUM_W'(COIN_50);
            default:  coin_units = '0;
        endcase
        case (select)
            SEL_20:  price_units = SUM_W'(PRICE_20);
            SEL_50:  price_units = SUM_W'(PRICE_50);
            default: price_units = '0;
        endcase
        coin_valid  = (money == MONEY_10) || (money == MONEY_50);
        credit_sum  = SUM_W'(credit) + coin_units;
        overflow    = credit_sum > SUM_W'(MAX_CREDIT);
        can_buy     = ((select == SEL_20) || (select == SEL_50)) &&
                      (SUM_W'(credit) >= price_units);
        in_take     = (state == ST_IDLE) || (state == ST_CREDIT);
        do_cancel   = (state == ST_CREDIT) && (cancel || timeout);
        do_buy      = in_take && !do_cancel && can_buy;
        coin_accept = in_take && coin_valid && !do_cancel && !do_buy && !overflow;
    end

`ifdef VEND_TIMEOUT_EN
    vend_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .run    (state == ST_CREDIT),
        .clear  (coin_accept),
        .expired(timeout)
    );
`else
    // No timer: credit is held indefinitely. The parameter is still referenced
    // so the interface stays identical in both builds; this is constant 0.
    assign timeout = (TIMEOUT_CYCLES < 0);
`endif

    // Controller FSM with all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            credit      <= '0;
            disp_req    <= 1'b0;
            disp_item   <= ITEM_NONE;
            chg_req     <= 1'b0;
            chg_amount  <= '0;
            busy        <= 1'b0;
            coin_reject <= 1'b0;
        end else begin
            coin_reject <= 1'b0;
            case (state)
                ST_IDLE, ST_CREDIT: begin
                    if (do_cancel) begin
                        state       <= ST_CHANGE;
                        chg_req     <= 1'b1;
                        chg_amount  <= credit;
                        busy        <= 1'b1;
                        coin_reject <= coin_valid;
                    end else if (do_buy) begin
                        state       <= ST_DISPENSE;
                        credit      <= credit - price_units[CREDIT_W-1:0];
                        disp_req    <= 1'b1;
                        disp_item   <= (select == SEL_20) ? ITEM_20 : ITEM_50;
                        busy        <= 1'b1;
                        coin_reject <= coin_valid;
                    end else if (coin_valid) begin
                        if (overflow) begin
                            coin_reject <= 1'b1;
                        end else begin
                            credit <= credit_sum[CREDIT_W-1:0];
                            state  <= ST_CREDIT;
                        end
                    end
                end
                ST_DISPENSE: begin
                    coin_reject <= coin_valid;
                    if (disp_ack) begin
                        disp_req  <= 1'b0;
                        disp_item <= ITEM_NONE;
                        if (credit != '0) begin
                            state      <= ST_CHANGE;
                            chg_req    <= 1'b1;
                            chg_amount <= credit;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                ST_CHANGE: begin
                    coin_reject <= coin_valid;
                    if (chg_ack) begin
                        state      <= ST_IDLE;
                        credit     <= '0;
                        chg_req    <= 1'b0;
                        chg_amount <= '0;
                        busy       <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vend_controller.sv
// Bench for vend_controller: directed stimulus, expected handshake events
// pushed to a queue and checked by an independent monitor.
module tb_vend_controller;

    localparam int CW = 4;

    // Event encoding: {kind[1:0], item[1:0], amount[3:0]}
    localparam logic [1:0] EV_DISP = 2'd1;
    localparam logic [1:0] EV_CHG  = 2'd2;
    localparam logic [1:0] EV_REJ  = 2'd3;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    money, select;
    logic          cancel, disp_ack, chg_ack;
    logic          disp_req, chg_req, busy, coin_reject;
    logic [1:0]    disp_item;
    logic [CW-1:0] chg_amount, credit;

    logic [7:0] exp_q[$];
    int total = 0;
    int bad   = 0;
    logic p_disp = 1'b0;
    logic p_chg  = 1'b0;

    vend_controller #(
        .CREDIT_W(CW),
        .MAX_CREDIT(10),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .money      (money),
        .select     (select),
        .cancel     (cancel),
        .disp_req   (disp_req),
        .disp_item  (disp_item),
        .disp_ack   (disp_ack),
        .chg_req    (chg_req),
        .chg_amount (chg_amount),
        .chg_ack    (chg_ack),
        .credit     (credit),
        .busy       (busy),
        .coin_reject(coin_reject)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pop_cmp(input string name, input logic [7:0] act);
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s: unexpected event %h, queue empty", name, act);
        end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (e != act) begin
                bad++;
                $display("FAIL %s: got event %h expected %h", name, act, e);
            end
        end
    endtask

    // monitor: request rises and reject pulses, checked against the queue
    always @(negedge clk) begin
        if (disp_req && !p_disp) pop_cmp("disp_event", {EV_DISP, disp_item, 4'd0});
        if (chg_req && !p_chg)   pop_cmp("chg_event", {EV_CHG, 2'd0, chg_amount});
        if (coin_reject)         pop_cmp("reject_event", {EV_REJ, 6'd0});
        p_disp = disp_req;
        p_chg  = chg_req;
    end

    // drive one cycle of inputs starting at a falling edge
    task automatic drive(input logic [1:0] m, input logic [1:0] s, input logic c,
                         input logic da, input logic ca);
        money = m; select = s; cancel = c; disp_ack = da; chg_ack = ca;
        @(negedge clk);
        money = 2'b00; select = 2'b00; cancel = 1'b0; disp_ack = 1'b0; chg_ack = 1'b0;
    endtask

    task automatic coin(input logic [1:0] m);
        drive(m, 2'b00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; money = 0; select = 0; cancel = 0; disp_ack = 0; chg_ack = 0;
        idle(2);
        reset = 1'b0;

        // reset state
        check("rst_credit", credit, 0);
        check("rst_disp_req", disp_req, 0);
        check("rst_disp_item", disp_item, 0);
        check("rst_chg_req", chg_req, 0);
        check("rst_chg_amount", chg_amount, 0);
        check("rst_busy", busy, 0);
        check("rst_reject", coin_reject, 0);

        // invalid coin code and cancel in IDLE are ignored
        coin(2'b11);
        drive(2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
        check("idle_ignore_credit", credit, 0);
        check("idle_cancel_chg", chg_req, 0);

        // two 10s, buy 20-item, ack -> IDLE with no change
        coin(2'b01);
        coin(2'b01);
        check("t1_credit2", credit, 2);
        exp_q.push_back({EV_DISP, 2'b01, 4'd0});
        drive(2'b00, 2'b01, 1'b0, 1'b0, 1'b0);
        check("t1_credit0", credit, 0);
        check("t1_busy", busy, 1);
        idle(2);
        check("t1_item_stable", disp_item, 1);
        drive(2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
        check("t1_disp_drop", disp_req, 0);
        check("t1_item_clear", disp_item, 0);
        check("t1_no_chg", chg_req, 0);
        check("t1_idle_busy", busy, 0);

        // 50, buy 20-item, change 3
        coin(2'b10);
        check("t2_credit5", credit, 5);
        exp_q.push_back({EV_DISP, 2'b01, 4'd0});
        drive(2'b00, 2'b01, 1'b0, 1'b0, 1'b0);
        exp_q.push_back({EV_CHG, 2'b00, 4'd3});
        drive(2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
        check("t2_chg_amount", chg_amount, 3);
        check("t2_busy", busy, 1);
        idle(1);
        drive(2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
        check("t2_credit_clr", credit, 0);
        check("t2_chg_drop", chg_req, 0);
        check("t2_busy_clr", busy, 0);

        // 50 x2 then 10 -> rejected, credit stays 10
        coin(2'b10);
        coin(2'b10);
        check("t3_credit10", credit, 10);
        exp_q.push_back({EV_REJ, 6'd0});
        coin(2'b01);
        check("t3_credit_hold", credit, 10);
        exp_q.push_back({EV_CHG, 2'b00, 4'd10});
        drive(2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
        drive(2'b00, 2'b00, 1'b0, 1'b0, 1'b1);

        // credit 3, cancel + select same cycle -> CHANGE 3, no dispense
        coin(2'b01);
        coin(2'b01);
        coin(2'b01);
        exp_q.push_back({EV_CHG, 2'b00, 4'd3});
        drive(2'b00, 2'b01, 1'b1, 1'b0, 1'b0);
        check("t4_no_disp", disp_req, 0);
        check("t4_chg_amount", chg_amount, 3);
        drive(2'b00, 2'b00, 1'b0, 1'b0, 1'b1);

        // 10, select 50-item ignored; coin during DISPENSE rejected
        coin(2'b01);
        drive(2'b00, 2'b10, 1'b0, 1'b0, 1'b0);
        check("t5_credit1", credit, 1);
        check("t5_not_busy", busy, 0);
        coin(2'b01);
        exp_q.push_back({EV_DISP, 2'b01, 4'd0});
        drive(2'b00, 2'b01, 1'b0, 1'b0, 1'b0);
        exp_q.push_back({EV_REJ, 6'd0});
        coin(2'b10);
        check("t5_credit_disp", credit, 0);
        drive(2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
        check("t5_idle", busy, 0);

        // reset mid-DISPENSE forfeits credit, asynchronously
        coin(2'b10);
        coin(2'b01);
        exp_q.push_back({EV_DISP, 2'b10, 4'd0});
        drive(2'b00, 2'b10, 1'b0, 1'b0, 1'b0);
        check("t6_credit1", credit, 1);
        #2 reset = 1'b1;
        #1;
        check("t6_rst_disp", disp_req, 0);
        check("t6_rst_item", disp_item, 0);
        check("t6_rst_credit", credit, 0);
        check("t6_rst_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;

`ifdef VEND_TIMEOUT_EN
        // idle credit refunded after the timeout, then reset mid-CHANGE
        exp_q.push_back({EV_CHG, 2'b00, 4'd1});
        coin(2'b01);
        for (int i = 0; i < 20 && !chg_req; i++) @(negedge clk);
        check("t7_timeout_chg", chg_req, 1);
        check("t7_timeout_amt", chg_amount, 1);
        #2 reset = 1'b1;
        #1;
        check("t7_rst_chg", chg_req, 0);
        check("t7_rst_amt", chg_amount, 0);
        check("t7_rst_credit", credit, 0);
        check("t7_rst_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;
`else
        // no timer: credit held indefinitely
        coin(2'b01);
        idle(20);
        check("t7_hold_chg", chg_req, 0);
        check("t7_hold_credit", credit, 1);
        exp_q.push_back({EV_CHG, 2'b00, 4'd1});
        drive(2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
        drive(2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
`endif

        idle(3);
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // global watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/vend_controller.md
VEND_CONTROLLER -- requirements
Module: vend_controller

Interface
REQ-001 SHALL have parameter CREDIT_W, default 4, credit register width in 10-dollar units.
REQ-002 SHALL have parameter MAX_CREDIT, default 10, maximum held credit in 10-dollar units (100 dollars).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000, idle-credit refund timeout in clk cycles.
REQ-004 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port money  input  2  coin this cycle: 01 = 10 dollars, 10 = 50 dollars, 00/11 = none.
REQ-007 SHALL have port select  input  2  item request: 01 = 20-dollar item, 10 = 50-dollar item, 00/11 = none.
REQ-008 SHALL have port cancel  input  1  refund request.
REQ-009 SHALL have port disp_req  output  1  dispense request to dispenser.
REQ-010 SHALL have port disp_item  output  2  item code: 00 none, 01 20-dollar, 10 50-dollar.
REQ-011 SHALL have port disp_ack  input  1  dispenser completion.
REQ-012 SHALL have port chg_req  output  1  change/refund request to coin return.
REQ-013 SHALL have port chg_amount  output  CREDIT_W  amount to return, 10-dollar units.
REQ-014 SHALL have port chg_ack  input  1  coin return completion.
REQ-015 SHALL have port credit  output  CREDIT_W  current held credit.
REQ-016 SHALL have port busy  output  1  high in DISPENSE or CHANGE.
REQ-017 SHALL have port coin_reject  output  1  one-cycle pulse, coin refused.

Function
REQ-018 States SHALL be IDLE (credit 0), CREDIT (credit > 0), DISPENSE, CHANGE.
REQ-019 Coins SHALL be accepted only in IDLE/CREDIT; credit updates next edge; IDLE -> CREDIT on first accepted coin.
REQ-020 Coin making credit exceed MAX_CREDIT SHALL leave credit unchanged and pulse coin_reject next cycle.
REQ-021 Coins in DISPENSE/CHANGE SHALL be refused with coin_reject pulse.
REQ-022 Per-cycle priority in CREDIT SHALL be cancel > select > money; lower-priority inputs that cycle are ignored (coin refused with coin_reject).
REQ-023 Select with credit >= price SHALL latch disp_item, deduct price from credit, enter DISPENSE next edge; insufficient credit ignored, no state change.
REQ-024 disp_req SHALL be high throughout DISPENSE; disp_item stable while disp_req high; disp_ack with disp_req low ignored.
REQ-025 On disp_ack: remaining credit > 0 -> CHANGE with chg_amount = credit; else -> IDLE; disp_req low and disp_item 00 the next cycle.
REQ-026 cancel in CREDIT SHALL enter CHANGE with chg_amount = full credit; cancel in IDLE/DISPENSE/CHANGE ignored.
REQ-027 chg_req SHALL be high throughout CHANGE with chg_amount stable; on chg_ack credit -> 0 and state -> IDLE next edge.
REQ-028 Minimum dispense latency: select edge -> disp_req high 1 cycle later; ack in the same cycle as disp_req rise is valid.

Reset
REQ-029 reset SHALL immediately force IDLE, credit 0, disp_req 0, disp_item 00, chg_req 0, chg_amount 0, busy 0, coin_reject 0, timer 0.
REQ-030 Reset mid-DISPENSE or mid-CHANGE SHALL drop requests without refund; held credit is forfeited.

Configuration
REQ-031 Macro VEND_TIMEOUT_EN defined: a timer counts cycles in CREDIT, cleared by any accepted coin or state exit; reaching TIMEOUT_CYCLES SHALL act as cancel.
REQ-032 VEND_TIMEOUT_EN undefined: no timer logic; credit held indefinitely; ports unchanged.

Structure
REQ-033 Package vend_pkg SHALL hold money/select/item codes, state encoding, prices (PRICE_20 = 2, PRICE_50 = 5 units).
REQ-034 Timer SHALL be sub-module vend_timer, instantiated only under VEND_TIMEOUT_EN.

Verification
REQ-035 Reset, coin 10 x2, select 20-item -> credit 2 -> 0, disp_req with disp_item 01, ack -> IDLE, no chg_req.
REQ-036 Coin 50, select 20-item, disp_ack -> chg_req with chg_amount 3, chg_ack -> credit 0, IDLE.
REQ-037 Coin 50 x2 then coin 10 -> credit 10, coin_reject pulse, credit remains 10.
REQ-038 Credit 3, cancel and select 20-item same cycle -> CHANGE, chg_amount 3, no disp_req.
REQ-039 Coin 10, select 50-item -> ignored, credit 1; coin in DISPENSE -> coin_reject, credit unchanged.
REQ-040 With VEND_TIMEOUT_EN, TIMEOUT_CYCLES=8: coin 10, idle 8 cycles -> chg_req with chg_amount 1; reset asserted mid-CHANGE -> all outputs 0 asynchronously.
